// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter and its pick logic.
//   - state_t   : arbiter FSM encoding (IDLE / GRANT)
//   - *_DEF     : default values for N_REQ, DATA_W and MAX_BURST
//   - id_w()    : width of a requester index for a given requester count
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int N_REQ_DEF     = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;

  // Index width; never collapses to zero bits for a single requester.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority selector.
// Searches the request vector starting one position above 'last' and
// wrapping modulo N_REQ; the first set bit wins.
//   req     : request vector
//   last    : index granted most recently (lowest priority this round)
//   pick    : one-hot winner, zero when no request
//   pick_id : index of the winner, zero when no request
//   any     : at least one request is set
module fifo_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] pick,
  output logic [ID_W-1:0]  pick_id,
  output logic             any
);

  always_comb begin
    logic found;
    int   k;
    pick    = '0;
    pick_id = '0;
    any     = |req;
    found   = 1'b0;
    k       = 0;
    // Offset N_REQ lands back on 'last' itself, so it is considered last.
    for (int off = 1; off <= N_REQ; off++) begin
      k = (int'(last) + off) % N_REQ;
      if (!found && req[k]) begin
        found   = 1'b1;
        pick[k] = 1'b1;
        pick_id = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between N_REQ producers.
// One producer is granted at a time for up to MAX_BURST beats; writes are
// never issued while the FIFO reports full.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_valid, i_data  : per-requester valid and packed data
//   o_ready          : per-requester accept (only the granted bit can be high)
//   i_fifo_full      : FIFO full flag
//   o_wr, o_data     : FIFO write strobe and data
//   o_grant          : one-hot current grant, zero when idle
//   o_grant_id       : index of the granted requester, zero when idle
//   o_busy           : high while a grant is held
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  localparam int ID_W     = id_w(N_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [N_REQ-1:0]        i_valid,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  output logic [N_REQ-1:0]        o_ready,
  input  logic                    i_fifo_full,
  output logic                    o_wr,
  output logic [DATA_W-1:0]       o_data,
  output logic [N_REQ-1:0]        o_grant,
  output logic [ID_W-1:0]         o_grant_id,
  output logic                    o_busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  state_t             state_reg, state_next;
  logic [N_REQ-1:0]   grant_reg, grant_next;
  logic [ID_W-1:0]    grant_id_reg, grant_id_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [ID_W-1:0]    last_reg, last_next;

  logic [N_REQ-1:0]   pick;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;

  logic [DATA_W-1:0]  data_arr [N_REQ];
  logic               sel_valid;
  logic [DATA_W-1:0]  sel_data;
  logic               accept;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = i_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  fifo_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req     (i_valid),
    .last    (last_reg),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (pick_any)
  );

  assign sel_valid = i_valid[grant_id_reg];
  assign sel_data  = data_arr[grant_id_reg];
  assign accept    = (state_reg == GRANT) && sel_valid && !i_fifo_full;

  assign o_grant    = grant_reg;
  assign o_grant_id = grant_id_reg;
  assign o_busy     = (state_reg == GRANT);

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    grant_id_next = grant_id_reg;
    cnt_next      = cnt_reg;
    last_next     = last_reg;
    o_ready       = '0;
    o_wr          = 1'b0;
    o_data        = '0;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          grant_next    = pick;
          grant_id_next = pick_id;
          cnt_next      = '0;
          state_next    = GRANT;
        end
      end
      GRANT: begin
        // Ready tracks the full flag only, so a stalled requester keeps its
        // grant even if it drops valid while the FIFO is full.
        o_ready = grant_reg & {N_REQ{~i_fifo_full}};
        o_wr    = accept;
        if (accept) begin
          o_data   = sel_data;
          cnt_next = cnt_reg + CNT_W'(1);
        end
        // Release either on the beat that completes the burst or when the
        // granted requester has gone idle with the FIFO able to take data.
        if ((accept && (cnt_reg == CNT_W'(MAX_BURST - 1))) ||
            (!sel_valid && !i_fifo_full)) begin
          state_next    = IDLE;
          grant_next    = '0;
          grant_id_next = '0;
          last_next     = grant_id_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      grant_id_reg <= '0;
      cnt_reg      <= '0;
      // Pointing at the top index gives requester 0 first priority.
      last_reg     <= ID_W'(N_REQ - 1);
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
      cnt_reg      <= cnt_next;
      last_reg     <= last_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed producer traffic with
// hand-derived write order, plus a randomised invariant sweep.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          i_reset_n;
  logic [N-1:0]  i_valid;
  logic [N*DW-1:0] i_data;
  logic [N-1:0]  o_ready;
  logic          i_fifo_full;
  logic          o_wr;
  logic [DW-1:0] o_data;
  logic [N-1:0]  o_grant;
  logic [1:0]    o_grant_id;
  logic          o_busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter dut (
    .i_clk       (clk),
    .i_reset_n   (i_reset_n),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .i_fifo_full (i_fifo_full),
    .o_wr        (o_wr),
    .o_data      (o_data),
    .o_grant     (o_grant),
    .o_grant_id  (o_grant_id),
    .o_busy      (o_busy)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] src_q[N][$];
  int compared = 0;
  int mism     = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int first_wr = -1;
  int last_wr  = -1;
  int occ      = 0;
  bit sweep    = 1'b0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    compared++;
    if (got !== want) begin
      mism++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endfunction

  task automatic expect_wr(int id, logic [7:0] d);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) until the scoreboard holds at most n entries.
  task automatic wait_exp(int n, int max_cyc, string name);
    int t = 0;
    while (exp_q.size() > n && t < max_cyc) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (exp_q.size() > n) begin
      compared++;
      mism++;
      $display("FAIL %s timeout: got %0d pending required %0d", name, exp_q.size(), n);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Producer model: each requester presents the head of its queue and pops
  // it after a handshake.
  initial begin
    logic [N-1:0]    acc;
    logic [N-1:0]    v;
    logic [N*DW-1:0] d;
    i_valid = '0;
    i_data  = '0;
    forever begin
      @(negedge clk);
      acc = i_valid & o_ready;
      @(posedge clk);
      #2;
      v = '0;
      d = '0;
      for (int k = 0; k < N; k++) begin
        if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0) begin
          v[k] = 1'b1;
          d[k*DW +: DW] = src_q[k][0];
        end
      end
      i_valid = v;
      i_data  = d;
    end
  end

  // Monitor: compares each FIFO write against the scoreboard.
  initial begin
    exp_t       e;
    logic [3:0] g_exp;
    forever begin
      @(negedge clk);
      if (sweep) begin
        chk("wr_while_full", 32'(o_wr & i_fifo_full), 32'd0);
        chk("grant_onehot0", 32'($onehot0(o_grant)), 32'd1);
        chk("ready_onehot0", 32'($onehot0(o_ready)), 32'd1);
        if (o_wr) begin
          chk("fifo_overflow", 32'(occ >= 16), 32'd0);
          occ++;
        end
      end else if (o_wr) begin
        if (exp_q.size() == 0) begin
          compared++;
          mism++;
          $display("FAIL unexpected_write: got id %0d data %h required no write", o_grant_id, o_data);
        end else begin
          e     = exp_q.pop_front();
          g_exp = 4'b0001 << e.id;
          compared++;
          if (o_grant_id !== e.id || o_data !== e.data || o_grant !== g_exp) begin
            mism++;
            $display("FAIL write: got id %0d grant %b data %h required id %0d grant %b data %h",
                     o_grant_id, o_grant, o_data, e.id, g_exp, e.data);
          end else begin
            $display("write id %0d data %h cycle %0d", o_grant_id, o_data, cyc);
          end
        end
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n   = 1'b0;
    i_fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_grant", 32'(o_grant), 32'd0);
    chk("reset_outputs", 32'({o_busy, o_wr, o_ready, o_grant_id, o_data}), 32'd0);
    i_reset_n = 1'b1;
    @(posedge clk);
    #1;

    // All requesting; asynchronous reset hits the first grant cycle.
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 4; j++) src_q[k].push_back(8'((k << 4) | j));
    for (int j = 4; j < 8; j++) src_q[0].push_back(8'(j));
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 4; j++) expect_wr(k, 8'((k << 4) | j));
    for (int j = 4; j < 8; j++) expect_wr(0, 8'(j));
    @(posedge clk);
    #1;
    chk("arb_latency_grant", 32'(o_grant), 32'b0001);
    #1;
    i_reset_n = 1'b0;
    #1;
    chk("async_reset_clears", 32'({o_grant, o_ready, o_wr, o_busy}), 32'd0);
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    wr_cnt    = 0;
    first_wr  = -1;
    @(posedge clk);
    #1;
    chk("first_grant_after_reset", 32'(o_grant), 32'b0001);
    wait_exp(0, 60, "all_req");
    chk("all_req_writes", 32'(wr_cnt), 32'd20);
    chk("all_req_span", 32'(last_wr - first_wr + 1), 32'd24);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_all", 32'(o_busy), 32'd0);

    // Single requester, six beats: burst limit then re-grant.
    for (int j = 0; j < 6; j++) begin
      src_q[2].push_back(8'(8'h10 + j));
      expect_wr(2, 8'(8'h10 + j));
    end
    wait_exp(2, 40, "single_first_burst");
    @(negedge clk);
    chk("burst_limit_idle", 32'({o_busy, o_wr}), 32'd0);
    @(negedge clk);
    chk("regrant_same", 32'(o_grant), 32'b0100);
    wait_exp(0, 40, "single_second_burst");
    repeat (3) @(posedge clk);
    #1;

    // Full stall after beat 2.
    for (int j = 0; j < 5; j++) begin
      src_q[0].push_back(8'(8'h40 + j));
      expect_wr(0, 8'(8'h40 + j));
    end
    wait_exp(3, 40, "full_pre");
    @(posedge clk);
    #1;
    i_fifo_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_no_write", 32'({o_wr, o_ready}), 32'd0);
      chk("stall_grant_held", 32'(o_grant), 32'b0001);
    end
    @(posedge clk);
    #1;
    i_fifo_full = 1'b0;
    wait_exp(1, 40, "full_post");
    @(negedge clk);
    chk("count_release_after_stall", 32'(o_busy), 32'd0);
    wait_exp(0, 40, "full_tail");
    repeat (3) @(posedge clk);
    #1;

    // Early release: requester 1 goes idle after one beat, 3 waits.
    src_q[1].push_back(8'h51);
    src_q[3].push_back(8'h73);
    expect_wr(1, 8'h51);
    expect_wr(3, 8'h73);
    wait_exp(1, 40, "early_first");
    @(negedge clk);
    chk("early_idle_cycle_in_grant", 32'({o_busy, o_wr}), 32'b10);
    @(negedge clk);
    chk("early_release_idle", 32'(o_busy), 32'd0);
    @(negedge clk);
    chk("early_next_grant", 32'(o_grant), 32'b1000);
    wait_exp(0, 40, "early_tail");
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Random safety sweep with a FIFO occupancy model.
    occ   = 0;
    sweep = 1'b1;
    repeat (3000) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 3) == 0 && src_q[k].size() < 3)
          src_q[k].push_back(8'($urandom));
      if (occ > 0 && $urandom_range(0, 2) == 0) occ--;
      i_fifo_full = (occ >= 16) || ($urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
